// File: rtl/hazard_pipe.sv
// Hazard unit for a 5-stage pipeline with memory-wait freeze,
// timeout fault detection and a saturating stall counter.
module hazard_pipe (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rsD,
    input  logic [4:0]  rtD,
    input  logic [4:0]  rsE,
    input  logic [4:0]  rtE,
    input  logic [4:0]  writeregE,
    input  logic [4:0]  writeregM,
    input  logic [4:0]  writeregW,
    input  logic        branchD,
    input  logic        regwriteE,
    input  logic        memtoregE,
    input  logic        regwriteM,
    input  logic        memtoregM,
    input  logic        memwriteM,
    input  logic        regwriteW,
    input  logic        dmemreadyM,
    output logic        stallF,
    output logic        stallD,
    output logic        flushE,
    output logic        stallE,
    output logic        stallM,
    output logic        flushW,
    output logic        forwardAD,
    output logic        forwardBD,
    output logic [1:0]  forwardAE,
    output logic [1:0]  forwardBE,
    output logic        memfault,
    output logic [15:0] stallcount
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t      r_state;
    logic [7:0]  r_waitcnt;
    logic [15:0] r_stallcount;

    logic w_memacc;
    logic w_miss;
    logic w_freeze;
    logic w_lwstall;
    logic w_brstall;
    logic w_hazard;

    function automatic logic [1:0] fwd_e(input logic [4:0] r);
        if (r != 5'd0 && regwriteM && writeregM == r)
            return 2'b10;
        else if (r != 5'd0 && regwriteW && writeregW == r)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign w_memacc  = memtoregM | memwriteM;
    assign w_miss    = w_memacc & ~dmemreadyM;
    assign w_freeze  = w_miss | (r_state == FAULT);
    assign w_lwstall = memtoregE & ((rtE == rsD) | (rtE == rtD));
    assign w_brstall = branchD &
        ((regwriteE & ((writeregE == rsD) | (writeregE == rtD))) |
         (memtoregM & ((writeregM == rsD) | (writeregM == rtD))));
    assign w_hazard  = w_lwstall | w_brstall;

    // A frozen pipe must not also squash D/E, or the held instruction is lost.
    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        flushE = 1'b0;
        stallE = 1'b0;
        stallM = 1'b0;
        flushW = 1'b0;
        if (w_freeze) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            flushW = 1'b1;
        end else begin
            stallF = w_hazard;
            stallD = w_hazard;
            flushE = w_hazard;
        end
    end

    assign forwardAE  = fwd_e(rsE);
    assign forwardBE  = fwd_e(rtE);
    assign forwardAD  = (rsD != 5'd0) & regwriteM & (writeregM == rsD);
    assign forwardBD  = (rtD != 5'd0) & regwriteM & (writeregM == rtD);
    assign memfault   = (r_state == FAULT);
    assign stallcount = r_stallcount;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_waitcnt <= 8'd0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_waitcnt <= 8'd0;
                    if (w_miss)
                        r_state <= WAIT;
                end
                WAIT: begin
                    if (dmemreadyM) begin
                        r_state   <= IDLE;
                        r_waitcnt <= 8'd0;
                    end else if (r_waitcnt == 8'd255) begin
                        r_state <= FAULT;
                    end else begin
                        r_waitcnt <= r_waitcnt + 8'd1;
                    end
                end
                FAULT: r_state <= FAULT;
                default: begin
                    r_state   <= IDLE;
                    r_waitcnt <= 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_stallcount <= 16'd0;
        else if (stallF && r_stallcount != 16'hFFFF)
            r_stallcount <= r_stallcount + 16'd1;
    end

endmodule

// File: tb/tb_hazard_pipe.sv
// Self-checking bench for hazard_pipe: per-cycle model compare
// plus directed scenarios with literal expectations.
module tb_hazard_pipe;

    logic        clk;
    logic        reset;
    logic [4:0]  rsD, rtD, rsE, rtE;
    logic [4:0]  writeregE, writeregM, writeregW;
    logic        branchD, regwriteE, memtoregE;
    logic        regwriteM, memtoregM, memwriteM;
    logic        regwriteW, dmemreadyM;
    logic        stallF, stallD, flushE, stallE, stallM, flushW;
    logic        forwardAD, forwardBD;
    logic [1:0]  forwardAE, forwardBE;
    logic        memfault;
    logic [15:0] stallcount;

    int checks = 0;
    int errors = 0;

    // Model state: fault flag, consecutive unready cycles, stall total
    logic m_fault = 1'b0;
    int   m_wait  = 0;
    int   m_cnt   = 0;

    hazard_pipe dut (
        .clk(clk), .reset(reset),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM),
        .writeregW(writeregW),
        .branchD(branchD), .regwriteE(regwriteE),
        .memtoregE(memtoregE), .regwriteM(regwriteM),
        .memtoregM(memtoregM), .memwriteM(memwriteM),
        .regwriteW(regwriteW), .dmemreadyM(dmemreadyM),
        .stallF(stallF), .stallD(stallD), .flushE(flushE),
        .stallE(stallE), .stallM(stallM), .flushW(flushW),
        .forwardAD(forwardAD), .forwardBD(forwardBD),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .memfault(memfault), .stallcount(stallcount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [1:0] m_fwd(input logic [4:0] r);
        if (r == 0) return 2'b00;
        if (regwriteM && writeregM == r) return 2'b10;
        if (regwriteW && writeregW == r) return 2'b01;
        return 2'b00;
    endfunction

    // {stallF,stallD,flushE,stallE,stallM,flushW,fAD,fBD,fAE,fBE,memfault}
    function automatic logic [12:0] m_rules(input logic fault);
        logic frz, lw, br, hz;
        logic [5:0] s;
        logic fad, fbd;
        frz = ((memtoregM || memwriteM) && !dmemreadyM) || fault;
        lw  = memtoregE && (rtE == rsD || rtE == rtD);
        br  = branchD &&
              ((regwriteE && (writeregE == rsD || writeregE == rtD)) ||
               (memtoregM && (writeregM == rsD || writeregM == rtD)));
        hz  = lw || br;
        s   = frz ? 6'b110111 : {hz, hz, hz, 3'b000};
        fad = rsD != 0 && regwriteM && writeregM == rsD;
        fbd = rtD != 0 && regwriteM && writeregM == rtD;
        return {s, fad, fbd, m_fwd(rsE), m_fwd(rtE), fault};
    endfunction

    always @(posedge clk) begin
        logic [12:0] e;
        e = m_rules(m_fault);
        if (reset) begin
            m_fault = 1'b0;
            m_wait  = 0;
            m_cnt   = 0;
        end else begin
            if (e[12] && m_cnt < 65535) m_cnt++;
            if (!m_fault) begin
                if (m_wait == 0) begin
                    if ((memtoregM || memwriteM) && !dmemreadyM)
                        m_wait = 1;
                end else if (dmemreadyM) begin
                    m_wait = 0;
                end else begin
                    m_wait++;
                    if (m_wait >= 257) m_fault = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [28:0] a, e;
        a = {stallF, stallD, flushE, stallE, stallM, flushW,
             forwardAD, forwardBD, forwardAE, forwardBE,
             memfault, stallcount};
        e = {m_rules(m_fault), 16'(m_cnt)};
        chk("cycle", 32'(a), 32'(e));
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr();
        rsD = 0; rtD = 0; rsE = 0; rtE = 0;
        writeregE = 0; writeregM = 0; writeregW = 0;
        branchD = 0; regwriteE = 0; memtoregE = 0;
        regwriteM = 0; memtoregM = 0; memwriteM = 0;
        regwriteW = 0; dmemreadyM = 1;
    endtask

    function automatic logic [5:0] ctl();
        return {stallF, stallD, flushE, stallE, stallM, flushW};
    endfunction

    initial begin
        reset = 1'b1;
        clr();
        step(2);
        reset = 1'b0;
        #2;
        chk("rst_count", 32'(stallcount), 32'd0);
        chk("rst_fault", 32'(memfault), 32'd0);
        chk("rst_ctl", 32'(ctl()), 32'd0);

        step(1);
        memtoregE = 1; rtE = 5; rsD = 5;
        #2;
        chk("lw_ctl", 32'(ctl()), 32'b111000);
        step(1);
        chk("lw_count", 32'(stallcount), 32'd1);

        clr();
        branchD = 1; regwriteE = 1; writeregE = 7; rtD = 7;
        #2;
        chk("br_ctl", 32'(ctl()), 32'b111000);
        step(1);
        chk("br_count", 32'(stallcount), 32'd2);
        regwriteE = 0; writeregE = 0;
        regwriteM = 1; writeregM = 7; memtoregM = 0;
        #2;
        chk("br_m_ctl", 32'(ctl()), 32'b000000);
        chk("br_fbd", 32'(forwardBD), 32'd1);
        step(1);

        clr();
        rsE = 3; regwriteM = 1; writeregM = 3;
        regwriteW = 1; writeregW = 3;
        #2;
        chk("fwd_prio", 32'(forwardAE), 32'b10);
        rsE = 0;
        #2;
        chk("fwd_r0", 32'(forwardAE), 32'b00);
        rsE = 3; regwriteM = 0;
        #2;
        chk("fwd_w", 32'(forwardAE), 32'b01);
        step(1);

        clr();
        memtoregM = 1; dmemreadyM = 0;
        memtoregE = 1; rtE = 5; rsD = 5;
        for (int i = 0; i < 4; i++) begin
            #2;
            chk("wait_ctl", 32'(ctl()), 32'b110111);
            step(1);
        end
        dmemreadyM = 1;
        #2;
        chk("ready_ctl", 32'(ctl()), 32'b111000);
        step(1);
        clr();
        dmemreadyM = 0;
        #2;
        chk("idle_ctl", 32'(ctl()), 32'b000000);
        step(1);

        clr();
        memtoregM = 1;
        #2;
        chk("fast_ctl", 32'(ctl()), 32'b000000);
        step(1);
        clr();
        step(1);

        memwriteM = 1; dmemreadyM = 0;
        step(256);
        chk("tmo_pre", 32'(memfault), 32'd0);
        step(1);
        chk("tmo_fault", 32'(memfault), 32'd1);
        memwriteM = 0; dmemreadyM = 1;
        #2;
        chk("tmo_frz", 32'(ctl()), 32'b110111);
        step(3);
        chk("tmo_hold", 32'(memfault), 32'd1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        #2;
        chk("tmo_rst_f", 32'(memfault), 32'd0);
        chk("tmo_rst_c", 32'(stallcount), 32'd0);
        chk("tmo_rst_ctl", 32'(ctl()), 32'b000000);

        memtoregE = 1; rtE = 5; rsD = 5;
        step(65534);
        chk("sat_pre", 32'(stallcount), 32'hFFFE);
        step(1);
        chk("sat_top", 32'(stallcount), 32'hFFFF);
        step(4465);
        chk("sat_hold", 32'(stallcount), 32'hFFFF);

        clr();
        step(2);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_pipe.md
HAZARD_PIPE -- requirements
Module: hazard_pipe

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; no other clock or asynchronous input is permitted.
REQ-002 The ports SHALL be, one per line, name  direction  width  meaning:
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- rsD, rtD  in  5 each  source register numbers in decode
- rsE, rtE  in  5 each  source register numbers in execute
- writeregE, writeregM, writeregW  in  5 each  destination register numbers
- branchD  in  1  branch in decode
- regwriteE, memtoregE  in  1 each  execute-stage controls
- regwriteM, memtoregM, memwriteM  in  1 each  memory-stage controls
- regwriteW  in  1  writeback register write
- dmemreadyM  in  1  data memory has completed the current access
- stallF, stallD  out  1 each  hold the PC register and the F/D register
- flushE  out  1  clear the D/E register
- stallE, stallM  out  1 each  hold the D/E and E/M registers
- flushW  out  1  insert a bubble into the M/W register
- forwardAD, forwardBD  out  1 each  decode comparator forward from M
- forwardAE, forwardBE  out  2 each  ALU operand select: 00 = register file, 10 = M, 01 = W
- memfault  out  1  sticky flag for a memory timeout
- stallcount  out  16  saturating count of stalled cycles

Function
REQ-003 memaccM SHALL be defined as memtoregM | memwriteM, and freeze SHALL be defined as (memaccM & ~dmemreadyM) | (state==FAULT).
REQ-004 The FSM SHALL have three states: IDLE, WAIT and FAULT.
- IDLE -> WAIT on memaccM & ~dmemreadyM.
- WAIT -> IDLE on dmemreadyM.
- WAIT -> FAULT when waitcnt==255 and dmemreadyM is still low.
- FAULT SHALL be left only by reset.
REQ-005 waitcnt (8 bit) SHALL:
- clear in IDLE;
- increment each cycle in WAIT while dmemreadyM is low;
- clear on the WAIT -> IDLE transition.
REQ-006 memfault SHALL be 1 exactly while state==FAULT.
REQ-007 lwstall SHALL be defined as memtoregE & (rtE==rsD | rtE==rtD).
REQ-008 brstall SHALL be defined as branchD & ((regwriteE & (writeregE==rsD | writeregE==rtD)) | (memtoregM & (writeregM==rsD | writeregM==rtD))).
REQ-009 When freeze=1, outputs SHALL be:
- stallF=stallD=stallE=stallM=1;
- flushW=1;
- flushE=0 (freeze has priority over lwstall and brstall).
REQ-010 When freeze=0, outputs SHALL be:
- stallF=stallD=flushE=lwstall|brstall;
- stallE=stallM=flushW=0.
REQ-011 forwardAE SHALL be:
- 10 if rsE!=0 & regwriteM & writeregM==rsE;
- else 01 if rsE!=0 & regwriteW & writeregW==rsE;
- else 00.
forwardBE SHALL follow the same rule using rtE.
REQ-012 forwardAD SHALL be rsD!=0 & regwriteM & writeregM==rsD, and forwardBD SHALL be the same using rtD.
REQ-013 All stall, flush and forward outputs SHALL be combinational from the current inputs and state, with zero latency.
REQ-014 stallcount SHALL increment by 1 on each clock edge where stallF=1, and SHALL saturate at 0xFFFF without wrapping.
REQ-015 A memory access that completes in the same cycle it is presented (dmemreadyM=1) SHALL cause no freeze and SHALL leave the state in IDLE.

Reset
REQ-016 While reset=1 at a clock edge, the block SHALL set state=IDLE, waitcnt=0 and stallcount=0, and memfault SHALL read 0 in the following cycle.
REQ-017 Reset asserted during WAIT or FAULT SHALL return the block to IDLE on that edge with freeze deasserted, unless memaccM & ~dmemreadyM still holds.
REQ-018 Combinational outputs SHALL depend only on the inputs and the reset-defined state; they SHALL NOT depend on any undefined register value.

Verification
REQ-019 The bench SHALL cover a load-use hazard: memtoregE=1, rtE=5, rsD=5, memaccM=0 -> stallF=stallD=flushE=1, stallE=0, and stallcount advances by 1.
REQ-020 The bench SHALL cover a branch hazard: branchD=1, regwriteE=1, writeregE=rtD=7 -> stallF=stallD=flushE=1; then with writeregE=7 only in M, regwriteM=1, memtoregM=0 -> no stall and forwardBD=1.
REQ-021 The bench SHALL cover forwarding priority: rsE=3, regwriteM=1, writeregM=3, regwriteW=1, writeregW=3 -> forwardAE=10; with rsE=0 under the same conditions -> forwardAE=00.
REQ-022 The bench SHALL cover a memory wait: memtoregM=1 with dmemreadyM low for 4 cycles then high -> freeze outputs held for 4 cycles, flushE=0 even if lwstall=1, and IDLE reached on the ready cycle.
REQ-023 The bench SHALL cover a memory timeout: memwriteM=1 with dmemreadyM held low -> FAULT entered after waitcnt reaches 255, memfault=1 and freeze held; reset -> memfault=0 and stallcount=0.
REQ-024 The bench SHALL cover stall-count saturation: stallF held at 1 for 70000 cycles -> stallcount=0xFFFF with no wrap.
